brom_rd_arbiter: RTL and testbench

//  Shares the single read port of the synchronous image-vector bROM (1-cycle read latency, no address-ready)

---
 rtl/brom_arb_pkg.sv | 42 ++++
 rtl/rr_arbiter.sv | 30 +++
 rtl/brom_rd_arbiter.sv | 108 ++++++++++
 tb/tb_brom_rd_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brom_arb_pkg.sv
// Shared types and helpers for the bROM read-port arbiter.
// Fallback widths let the block elaborate when the global config header is absent.
`ifndef CFG_IMG_VEC_NUM
`define CFG_IMG_VEC_NUM 16
`endif
`ifndef CFG_VEC_WIDTH
`define CFG_VEC_WIDTH 32
`endif

package brom_arb_pkg;

    localparam int unsigned MAX_REQ      = 8;
    localparam int unsigned MAX_ID_WIDTH = 3;

    typedef logic [MAX_ID_WIDTH-1:0] req_id_t;

    typedef struct packed {
        logic    vld;
        req_id_t id;
        logic    err;
    } inflight_t;

    // First set bit of req strictly after ptr, wrapping over n entries; ptr if none.
    function automatic req_id_t rr_next(input logic [MAX_REQ-1:0] req,
                                        input req_id_t            ptr,
                                        input int unsigned        n);
        req_id_t     idx;
        logic        hit;
        int unsigned c;
        idx = ptr;
        hit = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            c = (32'(ptr) + k) % n;
            if (k <= n && !hit && req[c[2:0]]) begin
                hit = 1'b1;
                idx = c[2:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker; the pointer register lives in the parent.
module rr_arbiter
    import brom_arb_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [MAX_REQ-1:0] req_pad;
    req_id_t            idx;
    logic               unused_idx_bits;

    always_comb begin
        req_pad        = '0;
        req_pad[N-1:0] = req;
        idx            = rr_next(req_pad, req_id_t'(ptr), N);
        gnt_idx        = idx[IW-1:0];
        gnt            = '0;
        if (en && |req) gnt[gnt_idx] = 1'b1;
    end

    assign unused_idx_bits = ^idx;

endmodule

// File: rtl/brom_rd_arbiter.sv
// Shares the single bROM read port among N_REQ fetch engines: round-robin grant,
// one outstanding read per requester, 1-deep registered response buffer each.
module brom_rd_arbiter
    import brom_arb_pkg::*;
#(
    parameter  int unsigned N_REQ      = 4,
    parameter  int unsigned ROM_DEPTH  = `CFG_IMG_VEC_NUM,
    parameter  int unsigned DATA_WIDTH = `CFG_VEC_WIDTH,
    parameter  int unsigned ADDR_WIDTH = $clog2(ROM_DEPTH),
    localparam int unsigned ID_WIDTH   = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            s_req_valid,
    input  logic [N_REQ*ADDR_WIDTH-1:0] s_req_addr,
    output logic [N_REQ-1:0]            s_req_ready,
    output logic [N_REQ-1:0]            s_resp_valid,
    input  logic [N_REQ-1:0]            s_resp_ready,
    output logic [N_REQ*DATA_WIDTH-1:0] s_resp_data,
    output logic [N_REQ-1:0]            s_resp_err,
    output logic                        m_arvalid,
    output logic [ADDR_WIDTH-1:0]       m_araddr,
    output logic                        m_rready,
    input  logic                        m_rvalid,
    input  logic [DATA_WIDTH-1:0]       m_rdata,
    output logic                        busy
);

    logic [N_REQ-1:0]      pend;
    logic [N_REQ-1:0]      resp_vld;
    logic [N_REQ-1:0]      resp_err;
    logic [N_REQ-1:0]      drain;
    logic [N_REQ-1:0]      elig;
    logic [N_REQ-1:0]      gnt;
    logic [ID_WIDTH-1:0]   ptr;
    logic [ID_WIDTH-1:0]   gnt_idx;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic                  any_gnt;
    logic                  in_range;
    logic                  wr_hits_valid;
    inflight_t             infl;
    logic [DATA_WIDTH-1:0] resp_buf [N_REQ];

    // A requester draining its buffer this cycle may re-issue in the same cycle.
    assign drain = resp_vld & s_resp_ready;
    assign elig  = s_req_valid & (~pend | drain);

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req     (elig),
        .ptr     (ptr),
        .en      (!rst),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        any_gnt   = |gnt;
        g_addr    = s_req_addr[32'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        in_range  = 32'(g_addr) < ROM_DEPTH;
        m_arvalid = any_gnt && in_range;
        m_araddr  = m_arvalid ? g_addr : '0;
    end

    assign m_rready     = m_arvalid;
    assign s_req_ready  = gnt;
    assign s_resp_valid = resp_vld;
    assign s_resp_err   = resp_err;
    assign busy         = |pend;

    always_comb begin
        s_resp_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++)
            s_resp_data[i*DATA_WIDTH +: DATA_WIDTH] = resp_buf[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= ID_WIDTH'(N_REQ - 1);
            infl     <= '0;
            pend     <= '0;
            resp_vld <= '0;
            resp_err <= '0;
            for (int unsigned i = 0; i < N_REQ; i++) resp_buf[i] <= '0;
        end else begin
            if (any_gnt) ptr <= gnt_idx;
            infl <= '{vld: any_gnt, id: req_id_t'(gnt_idx), err: any_gnt && !in_range};
            pend <= (pend & ~drain) | gnt;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (infl.vld && infl.id == req_id_t'(i)) begin
                    resp_vld[i] <= 1'b1;
                    resp_err[i] <= infl.err;
                    resp_buf[i] <= infl.err ? '0 : m_rdata;
                end else if (drain[i]) begin
                    resp_vld[i] <= 1'b0;
                    resp_err[i] <= 1'b0;
                end
            end
        end
    end

    assign wr_hits_valid = infl.vld && |(resp_vld & (N_REQ'(1) << infl.id));

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(s_req_ready));
    a_rvalid_follows: assert property (@(posedge clk) disable iff (rst) m_arvalid |=> m_rvalid);
    a_rvalid_only_after_ar: assert property (@(posedge clk) disable iff (rst) !m_arvalid |=> !m_rvalid);
    a_no_overwrite: assert property (@(posedge clk) disable iff (rst) !wr_hits_valid);

endmodule

// File: tb/tb_brom_rd_arbiter.sv
// Bench for brom_rd_arbiter: 16-word bROM model (word k = k+0x100) and a queue-based
// reference model of grants and responses compared every cycle.
module tb_brom_rd_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    s_req_valid, s_req_ready, s_resp_valid, s_resp_ready, s_resp_err;
    logic [N*AW-1:0] s_req_addr;
    logic [N*DW-1:0] s_resp_data;
    logic            m_arvalid, m_rready, busy;
    logic            m_rvalid = 1'b0;
    logic [AW-1:0]   m_araddr;
    logic [DW-1:0]   m_rdata = '0;

    brom_rd_arbiter #(
        .N_REQ      (N),
        .ROM_DEPTH  (DEPTH),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_req_valid  (s_req_valid),
        .s_req_addr   (s_req_addr),
        .s_req_ready  (s_req_ready),
        .s_resp_valid (s_resp_valid),
        .s_resp_ready (s_resp_ready),
        .s_resp_data  (s_resp_data),
        .s_resp_err   (s_resp_err),
        .m_arvalid    (m_arvalid),
        .m_araddr     (m_araddr),
        .m_rready     (m_rready),
        .m_rvalid     (m_rvalid),
        .m_rdata      (m_rdata),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // bROM: synchronous read, 1-cycle latency, sync active-low reset tied to ~rst
    logic [DW-1:0] rom [DEPTH];
    initial for (int k = 0; k < DEPTH; k++) rom[k] = DW'(k + 'h100);
    always @(posedge clk) begin
        if (rst) m_rvalid <= 1'b0;
        else begin
            m_rvalid <= m_arvalid && m_rready;
            m_rdata  <= rom[m_araddr[3:0]];
        end
    end

    int unsigned checks = 0;
    int unsigned failures = 0;

    logic [N-1:0] v, rr;
    int           addr [N];

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        longint        avail;
    } resp_t;

    resp_t  q [N][$];
    int     m_ptr;
    longint cyc;

    logic [N-1:0]  e_ready, e_rv;
    logic          e_arv, e_busy;
    logic [AW-1:0] e_addr;
    int            e_g;

    task automatic drive();
        s_req_valid  = v;
        s_resp_ready = rr;
        for (int i = 0; i < N; i++) s_req_addr[i*AW +: AW] = AW'(addr[i]);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) q[i].delete();
        m_ptr = N - 1;
        cyc   = 0;
    endtask

    task automatic model_eval();
        e_ready = '0; e_rv = '0; e_arv = 1'b0; e_addr = '0; e_busy = 1'b0; e_g = -1;
        for (int i = 0; i < N; i++) begin
            e_rv[i] = q[i].size() > 0 && q[i][0].avail <= cyc;
            if (q[i].size() > 0) e_busy = 1'b1;
        end
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (e_g < 0 && v[c] && (q[c].size() == 0 || (e_rv[c] && rr[c]))) e_g = c;
        end
        if (e_g >= 0) begin
            e_ready[e_g] = 1'b1;
            if (addr[e_g] < DEPTH) begin
                e_arv  = 1'b1;
                e_addr = AW'(addr[e_g]);
            end
        end
    endtask

    task automatic model_commit();
        for (int i = 0; i < N; i++)
            if (e_rv[i] && rr[i]) void'(q[i].pop_front());
        if (e_g >= 0) begin
            resp_t r;
            r.err   = addr[e_g] >= DEPTH;
            r.data  = r.err ? '0 : DW'(addr[e_g] + 'h100);
            r.avail = cyc + 2;
            q[e_g].push_back(r);
            m_ptr = e_g;
        end
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; v = '0; rr = '0;
        for (int i = 0; i < N; i++) addr[i] = 0;
        drive();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; v = '1; rr = '1;
        for (int i = 0; i < N; i++) addr[i] = i;
        drive();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({s_req_ready, s_resp_valid, s_resp_err, s_resp_data, m_arvalid, m_rready, m_araddr, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs ready=%b resp_valid=%b arvalid=%b busy=%b (required all 0)",
                     s_req_ready, s_resp_valid, m_arvalid, busy);
        end
        v = '0; drive();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (s_resp_valid !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release resp_valid=%b busy=%b (required 0/0)", s_resp_valid, busy);
        end
    endtask

    task automatic test_single();
        apply_reset();
        v = 4'b0001; rr = '1; addr[0] = 3;
        drive();
        #1;
        checks++;
        if (s_req_ready !== 4'b0001 || m_arvalid !== 1'b1 || m_rready !== 1'b1 || m_araddr !== AW'(3)) begin
            failures++;
            $display("FAIL single_grant ready=%b arvalid=%b rready=%b araddr=%0d (required 0001/1/1/3)",
                     s_req_ready, m_arvalid, m_rready, m_araddr);
        end
        @(negedge clk); v = '0; drive(); #1;
        checks++;
        if (s_resp_valid !== '0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_t1 resp_valid=%b busy=%b (required 0000/1)", s_resp_valid, busy);
        end
        @(negedge clk); #1;
        checks++;
        if (s_resp_valid !== 4'b0001 || s_resp_data[DW-1:0] !== 16'h0103 || s_resp_err[0] !== 1'b0) begin
            failures++;
            $display("FAIL single_resp valid=%b data=%h err=%b (required 0001/0103/0)",
                     s_resp_valid, s_resp_data[DW-1:0], s_resp_err[0]);
        end
        @(negedge clk); #1;
        checks++;
        if (s_resp_valid !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_drain resp_valid=%b busy=%b (required 0000/0)", s_resp_valid, busy);
        end
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        v = 4'b0010; rr = '1; addr[1] = 20;
        drive();
        #1;
        checks++;
        if (s_req_ready !== 4'b0010 || m_arvalid !== 1'b0 || m_rready !== 1'b0) begin
            failures++;
            $display("FAIL oor_grant ready=%b arvalid=%b rready=%b (required 0010/0/0)",
                     s_req_ready, m_arvalid, m_rready);
        end
        @(negedge clk); v = '0; drive(); #1;
        checks++;
        if (s_resp_valid !== '0 || m_arvalid !== 1'b0) begin
            failures++;
            $display("FAIL oor_t1 resp_valid=%b arvalid=%b (required 0000/0)", s_resp_valid, m_arvalid);
        end
        @(negedge clk); #1;
        checks++;
        if (s_resp_valid !== 4'b0010 || s_resp_data[2*DW-1:DW] !== '0 || s_resp_err !== 4'b0010) begin
            failures++;
            $display("FAIL oor_resp valid=%b data=%h err=%b (required 0010/0000/0010)",
                     s_resp_valid, s_resp_data[2*DW-1:DW], s_resp_err);
        end
    endtask

    task automatic test_stream();
        apply_reset();
        v = '1; rr = '1;
        for (int i = 0; i < N; i++) addr[i] = i;
        drive();
        for (int c = 0; c < 24; c++) begin
            #1;
            model_eval();
            if (c < 8) begin
                checks++;
                if (s_req_ready !== 4'(1 << (c % 4))) begin
                    failures++;
                    $display("FAIL stream_order cyc=%0d ready=%b (required %b)", c, s_req_ready, 4'(1 << (c % 4)));
                end
            end
            checks++;
            if (s_req_ready !== e_ready || m_arvalid !== e_arv || m_rready !== e_arv ||
                (e_arv && m_araddr !== e_addr) || s_resp_valid !== e_rv || busy !== e_busy) begin
                failures++;
                $display("FAIL stream cyc=%0d ready=%b/%b arvalid=%b/%b araddr=%0d/%0d resp_valid=%b/%b busy=%b/%b (got/required)",
                         c, s_req_ready, e_ready, m_arvalid, e_arv, m_araddr, e_addr, s_resp_valid, e_rv, busy, e_busy);
            end
            for (int i = 0; i < N; i++) if (e_rv[i]) begin
                checks++;
                if (s_resp_data[i*DW +: DW] !== q[i][0].data || s_resp_err[i] !== q[i][0].err) begin
                    failures++;
                    $display("FAIL stream_data cyc=%0d req=%0d data=%h/%h err=%b/%b (got/required)",
                             c, i, s_resp_data[i*DW +: DW], q[i][0].data, s_resp_err[i], q[i][0].err);
                end
            end
            model_commit();
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        int gnt2 = 0;
        apply_reset();
        v = '1;
        for (int c = 0; c < 26; c++) begin
            rr = (c < 12) ? 4'b1011 : 4'b1111;
            for (int i = 0; i < N; i++) addr[i] = int'($urandom_range(0, DEPTH - 1));
            drive();
            #1;
            model_eval();
            if (c < 12 && s_req_ready[2]) gnt2++;
            checks++;
            if (s_req_ready !== e_ready || m_arvalid !== e_arv || m_rready !== e_arv ||
                (e_arv && m_araddr !== e_addr) || s_resp_valid !== e_rv || busy !== e_busy) begin
                failures++;
                $display("FAIL stall cyc=%0d ready=%b/%b arvalid=%b/%b araddr=%0d/%0d resp_valid=%b/%b busy=%b/%b (got/required)",
                         c, s_req_ready, e_ready, m_arvalid, e_arv, m_araddr, e_addr, s_resp_valid, e_rv, busy, e_busy);
            end
            for (int i = 0; i < N; i++) if (e_rv[i]) begin
                checks++;
                if (s_resp_data[i*DW +: DW] !== q[i][0].data || s_resp_err[i] !== q[i][0].err) begin
                    failures++;
                    $display("FAIL stall_data cyc=%0d req=%0d data=%h/%h err=%b/%b (got/required)",
                             c, i, s_resp_data[i*DW +: DW], q[i][0].data, s_resp_err[i], q[i][0].err);
                end
            end
            model_commit();
            @(negedge clk);
        end
        checks++;
        if (gnt2 != 1) begin
            failures++;
            $display("FAIL stall_req2_grants got=%0d required=1", gnt2);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        v = '1; rr = '1;
        for (int i = 0; i < N; i++) addr[i] = i;
        drive();
        for (int c = 0; c < 5; c++) begin
            #1; model_eval(); model_commit();
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({s_req_ready, s_resp_valid, s_resp_err, s_resp_data, m_arvalid, m_rready, m_araddr, busy} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs ready=%b resp_valid=%b arvalid=%b busy=%b (required all 0)",
                     s_req_ready, s_resp_valid, m_arvalid, busy);
        end
        @(negedge clk);
        v = '0; drive();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (s_resp_valid !== '0 || busy !== 1'b0 || m_arvalid !== 1'b0) begin
                failures++;
                $display("FAIL midreset_stale cyc=%0d resp_valid=%b busy=%b arvalid=%b (required 0000/0/0)",
                         c, s_resp_valid, busy, m_arvalid);
            end
            @(negedge clk);
        end
        v = '1; drive();
        #1;
        checks++;
        if (s_req_ready !== 4'b0001 || m_araddr !== AW'(0) || m_arvalid !== 1'b1) begin
            failures++;
            $display("FAIL midreset_first_grant ready=%b arvalid=%b araddr=%0d (required 0001/1/0)",
                     s_req_ready, m_arvalid, m_araddr);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                v[i]    = $urandom_range(0, 99) < 35;
                rr[i]   = $urandom_range(0, 99) < 60;
                addr[i] = int'($urandom_range(0, 23));
            end
            drive();
            #1;
            model_eval();
            checks++;
            if (s_req_ready !== e_ready || m_arvalid !== e_arv || m_rready !== e_arv ||
                (e_arv && m_araddr !== e_addr) || s_resp_valid !== e_rv || busy !== e_busy) begin
                failures++;
                $display("FAIL random cyc=%0d ready=%b/%b arvalid=%b/%b araddr=%0d/%0d resp_valid=%b/%b busy=%b/%b (got/required)",
                         c, s_req_ready, e_ready, m_arvalid, e_arv, m_araddr, e_addr, s_resp_valid, e_rv, busy, e_busy);
            end
            for (int i = 0; i < N; i++) if (e_rv[i]) begin
                checks++;
                if (s_resp_data[i*DW +: DW] !== q[i][0].data || s_resp_err[i] !== q[i][0].err) begin
                    failures++;
                    $display("FAIL random_data cyc=%0d req=%0d data=%h/%h err=%b/%b (got/required)",
                             c, i, s_resp_data[i*DW +: DW], q[i][0].data, s_resp_err[i], q[i][0].err);
                end
            end
            model_commit();
            @(negedge clk);
        end
        v = '0; rr = '1; drive();
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (s_resp_valid !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL random_drain resp_valid=%b busy=%b (required 0000/0)", s_resp_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_out_of_range();
        test_stream();
        test_stall();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
